acq_write_ctrl: RTL and testbench

//   Write-enable and address generator for BRAM acquisition buffers.

---
 rtl/acq_write_ctrl_pkg.sv | 19 +
 rtl/acq_write_ctrl_addr_counter.sv | 30 +++
 rtl/acq_write_ctrl.sv | 121 ++++++++++++
 tb/tb_acq_write_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/acq_write_ctrl_pkg.sv
// Shared types and helpers for the acquisition write controller.
// Holds the FSM state encoding and the acquisition-length clamp.
package acq_write_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A length of 0, or one larger than the buffer, means "fill the whole buffer".
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input int bw);
        logic [31:0] full;
        full = 32'd1 << bw;
        return ((len == 32'd0) || (len > full)) ? full : len;
    endfunction

endpackage

// File: rtl/acq_write_ctrl_addr_counter.sv
// BRAM write-address counter: synchronous clear, increment, and a
// terminal-count flag raised while the address equals the programmed last word.
module acq_write_ctrl_addr_counter #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_addr,
    output logic         o_tc
);

    logic [W-1:0] r_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = (r_addr == i_last);

endmodule

// File: rtl/acq_write_ctrl.sv
// Write-enable and address generator for BRAM acquisition buffers:
// arm, wait for trigger, write len_lat words, then finish or re-arm.
module acq_write_ctrl
    import acq_write_ctrl_pkg::*;
#(
    parameter int BRAM_WIDTH = 13,
    parameter int N_CH       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_acq,
    input  logic                  stop_acq,
    input  logic                  trig,
    input  logic [BRAM_WIDTH:0]   len,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic                  continuous,
    output logic [BRAM_WIDTH-1:0] addr,
    output logic [N_CH-1:0]       wen,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  acq_count,
    output state_t                dbg_state
);

    localparam int LEN_WIDTH = BRAM_WIDTH + 1;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len_lat;
    logic [N_CH-1:0]       r_mask_lat;
    logic                  r_cont_lat;
    logic [N_CH-1:0]       r_wen;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_acq_count;

    logic [BRAM_WIDTH-1:0] w_last;
    logic                  w_tc;
    logic                  w_clr;
    logic                  w_inc;

    // len_lat is at least 1, so len_lat-1 always fits in the address width.
    assign w_last = BRAM_WIDTH'(r_len_lat - LEN_WIDTH'(1));
    assign w_clr  = stop_acq || ((r_state == ST_ACQ) && w_tc);
    assign w_inc  = (r_state == ST_ACQ) && !w_tc && !stop_acq;

    acq_write_ctrl_addr_counter #(
        .W (BRAM_WIDTH)
    ) u_addr_counter (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .i_last (w_last),
        .o_addr (addr),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_len_lat   <= '0;
            r_mask_lat  <= '0;
            r_cont_lat  <= 1'b0;
            r_wen       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acq_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop_acq) begin
                r_state <= ST_IDLE;
                r_wen   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start_acq) begin
                            r_len_lat   <= LEN_WIDTH'(clamp_len(32'(len), BRAM_WIDTH));
                            r_mask_lat  <= ch_mask;
                            r_cont_lat  <= continuous;
                            r_acq_count <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            r_wen   <= r_mask_lat;
                            r_state <= ST_ACQ;
                        end
                    end
                    ST_ACQ: begin
                        // The edge that retires the last word also ends the burst.
                        if (w_tc) begin
                            r_wen <= '0;
                            if (r_acq_count != '1) begin
                                r_acq_count <= r_acq_count + CNT_WIDTH'(1);
                            end
                            if (r_cont_lat) begin
                                r_state <= ST_ARMED;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wen       = r_wen;
    assign busy      = r_busy;
    assign done      = r_done;
    assign acq_count = r_acq_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_acq_write_ctrl.sv
// Directed bench for acq_write_ctrl with BRAM_WIDTH=4, N_CH=2.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_acq_write_ctrl;
    import acq_write_ctrl_pkg::*;

    localparam int BW = 4;
    localparam int NC = 2;
    localparam int CW = 16;

    logic          clk;
    logic          resetn;
    logic          start_acq;
    logic          stop_acq;
    logic          trig;
    logic [BW:0]   len;
    logic [NC-1:0] ch_mask;
    logic          continuous;
    logic [BW-1:0] addr;
    logic [NC-1:0] wen;
    logic          busy;
    logic          done;
    logic [CW-1:0] acq_count;
    state_t        dbg_state;

    int n_checks;
    int n_pass;

    acq_write_ctrl #(
        .BRAM_WIDTH (BW),
        .N_CH       (NC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_acq  (start_acq),
        .stop_acq   (stop_acq),
        .trig       (trig),
        .len        (len),
        .ch_mask    (ch_mask),
        .continuous (continuous),
        .addr       (addr),
        .wen        (wen),
        .busy       (busy),
        .done       (done),
        .acq_count  (acq_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [BW:0] l, input logic [NC-1:0] m, input logic c);
        start_acq  = 1'b1;
        len        = l;
        ch_mask    = m;
        continuous = c;
        tick();
        start_acq  = 1'b0;
        check("arm_busy",  32'(busy), 32'd1);
        check("arm_wen",   32'(wen), 32'd0);
        check("arm_state", 32'(dbg_state), 32'(ST_ARMED));
    endtask

    task automatic expect_burst(input int first, input int n, input logic [NC-1:0] m);
        for (int i = 0; i < n; i++) begin
            tick();
            check("burst_wen",  32'(wen), 32'(m));
            check("burst_addr", 32'(addr), 32'(first + i));
            check("burst_busy", 32'(busy), 32'd1);
            check("burst_done", 32'(done), 32'd0);
        end
    endtask

    task automatic expect_single_end(input int cnt);
        tick();
        check("end_wen",   32'(wen), 32'd0);
        check("end_done",  32'(done), 32'd1);
        check("end_busy",  32'(busy), 32'd0);
        check("end_addr",  32'(addr), 32'd0);
        check("end_count", 32'(acq_count), 32'(cnt));
        tick();
        check("post_done",  32'(done), 32'd0);
        check("post_state", 32'(dbg_state), 32'(ST_DONE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        resetn     = 1'b0;
        start_acq  = 1'b0;
        stop_acq   = 1'b0;
        trig       = 1'b0;
        len        = '0;
        ch_mask    = '0;
        continuous = 1'b0;
        repeat (3) tick();
        check("rst_addr",  32'(addr), 32'd0);
        check("rst_wen",   32'(wen), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_count", 32'(acq_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        resetn = 1'b1;
        tick();

        // 1: len=5 single shot, immediate trigger
        trig = 1'b1;
        arm(5'd5, 2'b11, 1'b0);
        expect_burst(0, 5, 2'b11);
        expect_single_end(1);

        // 2: len=0 and len=31 both clamp to 16; len=1 writes once at addr 0
        arm(5'd0, 2'b11, 1'b0);
        expect_burst(0, 16, 2'b11);
        expect_single_end(1);
        arm(5'd31, 2'b10, 1'b0);
        expect_burst(0, 16, 2'b10);
        expect_single_end(1);
        arm(5'd1, 2'b01, 1'b0);
        expect_burst(0, 1, 2'b01);
        expect_single_end(1);

        // 3: continuous, trigger held: one idle cycle between bursts
        arm(5'd3, 2'b11, 1'b1);
        for (int b = 1; b <= 3; b++) begin
            expect_burst(0, 3, 2'b11);
            tick();
            check("cont_gap_wen",   32'(wen), 32'd0);
            check("cont_gap_done",  32'(done), 32'd0);
            check("cont_gap_busy",  32'(busy), 32'd1);
            check("cont_gap_count", 32'(acq_count), 32'(b));
        end
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        check("cont_stop_busy",  32'(busy), 32'd0);
        check("cont_stop_state", 32'(dbg_state), 32'(ST_IDLE));
        check("cont_stop_count", 32'(acq_count), 32'd3);
        check("cont_stop_wen",   32'(wen), 32'd0);

        // 4: stop at the third write of len=8; then stop+start together
        arm(5'd8, 2'b11, 1'b0);
        expect_burst(0, 3, 2'b11);
        stop_acq = 1'b1;
        tick();
        stop_acq = 1'b0;
        check("stop_wen",   32'(wen), 32'd0);
        check("stop_addr",  32'(addr), 32'd0);
        check("stop_busy",  32'(busy), 32'd0);
        check("stop_done",  32'(done), 32'd0);
        check("stop_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("stop_done2", 32'(done), 32'd0);
        start_acq = 1'b1;
        stop_acq  = 1'b1;
        tick();
        start_acq = 1'b0;
        stop_acq  = 1'b0;
        check("stopstart_state", 32'(dbg_state), 32'(ST_IDLE));
        check("stopstart_busy",  32'(busy), 32'd0);

        // 5: start during ACQ with different config is ignored
        arm(5'd4, 2'b11, 1'b0);
        expect_burst(0, 2, 2'b11);
        start_acq  = 1'b1;
        len        = 5'd2;
        ch_mask    = 2'b01;
        continuous = 1'b1;
        expect_burst(2, 2, 2'b11);
        start_acq  = 1'b0;
        expect_single_end(1);

        // 5b: trigger low holds ARMED with no writes
        trig = 1'b0;
        arm(5'd5, 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wait_wen",   32'(wen), 32'd0);
            check("wait_busy",  32'(busy), 32'd1);
            check("wait_state", 32'(dbg_state), 32'(ST_ARMED));
        end
        trig = 1'b1;
        expect_burst(0, 5, 2'b11);
        expect_single_end(1);

        // zero mask: sequence runs, nothing written
        arm(5'd2, 2'b00, 1'b0);
        expect_burst(0, 2, 2'b00);
        expect_single_end(1);

        // 6: async reset in the middle of the second continuous burst
        arm(5'd3, 2'b11, 1'b1);
        expect_burst(0, 3, 2'b11);
        tick();
        check("pre_rst_count", 32'(acq_count), 32'd1);
        expect_burst(0, 2, 2'b11);
        #2;
        resetn = 1'b0;
        #1;
        check("async_addr",  32'(addr), 32'd0);
        check("async_wen",   32'(wen), 32'd0);
        check("async_busy",  32'(busy), 32'd0);
        check("async_count", 32'(acq_count), 32'd0);
        check("async_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        resetn = 1'b1;
        tick();
        check("after_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("after_rst_wen",   32'(wen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
